// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: the stage occupancy
// encoding and the NOP payload every stage instance agrees on.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam int          MAX_DATA_W     = 64;
    localparam logic [63:0] DEFAULT_BUBBLE = 64'h0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the per-stage performance counters.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    // Count up on inc, stick at all-ones, clear only on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (inc && (value != {CNT_W{1'b1}})) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a 2-entry skid buffer, bubble-inserting
// flush, global freeze and saturating stall/flush counters.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(DEFAULT_BUBBLE),
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              freeze,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    stage_state_t      state, state_nxt;
    logic [DATA_W-1:0] main_data, main_nxt;
    logic [DATA_W-1:0] skid_data, skid_nxt;
    logic              main_valid;
    logic              accept;
    logic              drain;
    logic              stall_inc;
    logic              flush_inc;

    // Handshake decode depends only on registered state and freeze.
    always_comb begin
        main_valid = (state != ST_EMPTY);
        in_ready   = (state != ST_TWO) && !freeze;
        out_valid  = main_valid && !freeze;
        out_data   = main_valid ? main_data : BUBBLE_VAL;
        accept     = in_valid && in_ready;
        drain      = out_valid && out_ready;
        stall_inc  = in_valid && !in_ready;
        flush_inc  = flush && ((state == ST_TWO) ||
                               ((state == ST_ONE) && !drain) ||
                               accept);
    end

    // Next-state and storage update; flush beats freeze beats normal flow.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_data;
        skid_nxt  = skid_data;
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_nxt  = BUBBLE_VAL;
            skid_nxt  = BUBBLE_VAL;
        end else if (!freeze) begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        main_nxt  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_nxt = in_data;
                    end else if (accept) begin
                        state_nxt = ST_TWO;
                        skid_nxt  = in_data;
                    end else if (drain) begin
                        state_nxt = ST_EMPTY;
                        main_nxt  = BUBBLE_VAL;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_nxt = ST_ONE;
                        main_nxt  = skid_data;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                    main_nxt  = BUBBLE_VAL;
                    skid_nxt  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            main_data <= BUBBLE_VAL;
            skid_data <= BUBBLE_VAL;
        end else begin
            state     <= state_nxt;
            main_data <= main_nxt;
            skid_data <= skid_nxt;
        end
    end

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .value (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .value (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage; a second instance with
// 2-bit counters shares the stimulus to exercise counter saturation.
module tb_pipe_skid_stage;

    localparam logic [63:0] BUB = 64'hDEAD_BEEF_0000_0000;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        flush;
    logic        freeze;

    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [15:0] stall_cnt, flush_cnt;

    logic        in_ready_s, out_valid_s;
    logic [63:0] out_data_s;
    logic [1:0]  stall_cnt_s, flush_cnt_s;

    int tests_run;
    int tests_failed;

    pipe_skid_stage #(.DATA_W(64), .BUBBLE_VAL(BUB), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .freeze    (freeze),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    pipe_skid_stage #(.DATA_W(64), .BUBBLE_VAL(BUB), .CNT_W(2)) dut_small (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_data_s),
        .flush     (flush),
        .freeze    (freeze),
        .stall_cnt (stall_cnt_s),
        .flush_cnt (flush_cnt_s)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic iv, input logic [63:0] id,
                                 input logic ordy, input logic fl,
                                 input logic fz);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        freeze    = fz;
        #1;
    endtask

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset values.
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
        checkOutput("rst_out_data",  out_data,       BUB);
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("rst_flush_cnt", 64'(flush_cnt), 64'd0);

        // Four beats 0xA..0xD streamed with out_ready high.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 64'(10 + i), 1'b1, 1'b0, 1'b0);
            checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
            if (i > 0) begin
                checkOutput("stream_out_valid", 64'(out_valid), 64'd1);
                checkOutput("stream_out_data", out_data, 64'(10 + i - 1));
            end
            tick();
        end
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("stream_last_valid", 64'(out_valid), 64'd1);
        checkOutput("stream_last_data",  out_data,       64'hD);
        tick();
        checkOutput("stream_empty_valid", 64'(out_valid), 64'd0);
        checkOutput("stream_empty_data",  out_data,       BUB);
        checkOutput("stream_stall_cnt",   64'(stall_cnt), 64'd0);

        // Backpressure: 0x1,0x2,0x3 with out_ready low from the 2nd cycle.
        applyStimulus(1'b1, 64'h1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_ready_one", 64'(in_ready), 64'd1);
        checkOutput("bp_data_one",  out_data,      64'h1);
        tick();
        applyStimulus(1'b1, 64'h3, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_ready_two", 64'(in_ready), 64'd0);
        checkOutput("bp_data_two",  out_data,      64'h1);
        tick();
        applyStimulus(1'b1, 64'h3, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_stall_1", 64'(stall_cnt), 64'd1);
        tick();
        applyStimulus(1'b1, 64'h3, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_stall_2",   64'(stall_cnt), 64'd2);
        checkOutput("bp_deliver_1", out_data,       64'h1);
        checkOutput("bp_ready_hi",  64'(in_ready),  64'd0);
        tick();
        applyStimulus(1'b1, 64'h3, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_stall_3",   64'(stall_cnt), 64'd3);
        checkOutput("bp_deliver_2", out_data,       64'h2);
        checkOutput("bp_ready_back", 64'(in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_deliver_3", out_data,        64'h3);
        checkOutput("bp_valid_3",   64'(out_valid),  64'd1);
        tick();
        checkOutput("bp_drained", 64'(out_valid), 64'd0);

        // Flush while holding two beats: the draining one still completes.
        applyStimulus(1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("fl_valid_in_cycle", 64'(out_valid), 64'd1);
        checkOutput("fl_data_in_cycle",  out_data,       64'h1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("fl_valid_after", 64'(out_valid), 64'd0);
        checkOutput("fl_data_after",  out_data,       BUB);
        checkOutput("fl_ready_after", 64'(in_ready),  64'd1);
        checkOutput("fl_cnt_1",       64'(flush_cnt), 64'd1);
        // Flush of an empty stage kills nothing and is not counted.
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("fl_empty_cnt", 64'(flush_cnt), 64'd1);
        // Flush that kills the beat entering this cycle is counted.
        applyStimulus(1'b1, 64'h7, 1'b1, 1'b1, 1'b0);
        checkOutput("fl_acc_ready", 64'(in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("fl_acc_valid", 64'(out_valid), 64'd0);
        checkOutput("fl_acc_cnt",   64'(flush_cnt), 64'd2);
        checkOutput("fl_stall_kept", 64'(stall_cnt), 64'd3);

        // Freeze for three cycles with 0x5 held and upstream waiting.
        applyStimulus(1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 64'h6, 1'b1, 1'b0, 1'b1);
            checkOutput("fz_out_valid", 64'(out_valid), 64'd0);
            checkOutput("fz_in_ready",  64'(in_ready),  64'd0);
            checkOutput("fz_data_hold", out_data,       64'h5);
            tick();
        end
        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("fz_release_valid", 64'(out_valid), 64'd1);
        checkOutput("fz_release_data",  out_data,       64'h5);
        checkOutput("fz_stall_cnt",     64'(stall_cnt), 64'd6);
        checkOutput("fz_flush_hold",    64'(flush_cnt), 64'd2);
        checkOutput("sat_stall_cnt",    64'(stall_cnt_s), 64'd3);
        tick();
        checkOutput("fz_drained", 64'(out_valid), 64'd0);

        // Reset while two beats are held and upstream is stalled.
        applyStimulus(1'b1, 64'h8, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'h9, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_out_valid", 64'(out_valid),   64'd0);
        checkOutput("midrst_in_ready",  64'(in_ready),    64'd1);
        checkOutput("midrst_out_data",  out_data,         BUB);
        checkOutput("midrst_stall_cnt", 64'(stall_cnt),   64'd0);
        checkOutput("midrst_flush_cnt", 64'(flush_cnt),   64'd0);
        checkOutput("midrst_sat_cnt",   64'(stall_cnt_s), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
